// File: rtl/sdram_req_arbiter_if.sv
// rtl/sdram_req_arbiter_if.sv - request port between the arbiter and the sdram controller
interface sdram_req_arbiter_if #(
    parameter int AW = 24,
    parameter int DW = 16
);
    logic          mem_wr_req;
    logic          mem_rd_req;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_wr_ack;
    logic          mem_rd_valid;
    logic [DW-1:0] mem_rd_data;

    // arbiter side drives the request, controller side answers it
    modport master (
        output mem_wr_req, mem_rd_req, mem_addr, mem_wdata,
        input  mem_wr_ack, mem_rd_valid, mem_rd_data
    );

    modport slave (
        input  mem_wr_req, mem_rd_req, mem_addr, mem_wdata,
        output mem_wr_ack, mem_rd_valid, mem_rd_data
    );
endinterface

// File: rtl/sdram_req_arbiter.sv
// rtl/sdram_req_arbiter.sv - two-client round-robin arbiter for one sdram request port (optional wait timeout: SDRAM_ARB_TIMEOUT_EN)
module sdram_req_arbiter #(
    parameter int AW      = 24,
    parameter int DW      = 16,
    parameter int TIMEOUT = 1023
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    c0_req,
    input  logic                    c0_we,
    input  logic [AW-1:0]           c0_addr,
    input  logic [DW-1:0]           c0_wdata,
    output logic                    c0_done,
    input  logic                    c1_req,
    input  logic                    c1_we,
    input  logic [AW-1:0]           c1_addr,
    input  logic [DW-1:0]           c1_wdata,
    output logic                    c1_done,
    output logic [DW-1:0]           rdata,
    output logic                    err,
    sdram_req_arbiter_if.master     mem
);

    typedef enum logic [1:0] {IDLE, WR_WAIT, RD_WAIT, DONE} state_t;

    state_t        state_q, state_d;
    logic          prio_q, prio_d;      // client favoured when both request
    logic          gnt_q, gnt_d;        // client owning the transaction in flight
    logic          wr_req_q, wr_req_d;
    logic          rd_req_q, rd_req_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          done0_q, done0_d;
    logic          done1_q, done1_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          err_q, err_d;

    logic          pick;
    logic          pick_we;

`ifdef SDRAM_ARB_TIMEOUT_EN
    localparam int            CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    logic [CW-1:0] cnt_q, cnt_d;
`else
    localparam int timeout_unused = TIMEOUT;
`endif

    // choose which client wins the next grant and its direction
    always_comb begin
        pick = 1'b0;
        if (c0_req && c1_req) begin
            pick = prio_q;
        end else if (c1_req) begin
            pick = 1'b1;
        end
        pick_we = pick ? c1_we : c0_we;
    end

    // next-state and next-output computation for the transaction FSM
    always_comb begin
        state_d  = state_q;
        prio_d   = prio_q;
        gnt_d    = gnt_q;
        wr_req_d = wr_req_q;
        rd_req_d = rd_req_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        done0_d  = 1'b0;
        done1_d  = 1'b0;
        err_d    = 1'b0;
`ifdef SDRAM_ARB_TIMEOUT_EN
        cnt_d    = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (c0_req || c1_req) begin
                    gnt_d    = pick;
                    prio_d   = ~pick;
                    addr_d   = pick ? c1_addr : c0_addr;
                    wdata_d  = pick ? c1_wdata : c0_wdata;
                    wr_req_d = pick_we;
                    rd_req_d = ~pick_we;
                    state_d  = pick_we ? WR_WAIT : RD_WAIT;
`ifdef SDRAM_ARB_TIMEOUT_EN
                    cnt_d    = '0;
`endif
                end
            end
            WR_WAIT: begin
                if (mem.mem_wr_ack) begin
                    wr_req_d = 1'b0;
                    done0_d  = ~gnt_q;
                    done1_d  = gnt_q;
                    state_d  = DONE;
                end
`ifdef SDRAM_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    wr_req_d = 1'b0;
                    done0_d  = ~gnt_q;
                    done1_d  = gnt_q;
                    err_d    = 1'b1;
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            RD_WAIT: begin
                if (mem.mem_rd_valid) begin
                    rdata_d  = mem.mem_rd_data;
                    rd_req_d = 1'b0;
                    done0_d  = ~gnt_q;
                    done1_d  = gnt_q;
                    state_d  = DONE;
                end
`ifdef SDRAM_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    rd_req_d = 1'b0;
                    done0_d  = ~gnt_q;
                    done1_d  = gnt_q;
                    err_d    = 1'b1;
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: begin
                // DONE: give the client a cycle to drop req before re-arbitrating
                state_d = IDLE;
            end
        endcase
    end

    // register all state and outputs; reset returns to IDLE with client 0 favoured
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            prio_q   <= 1'b0;
            gnt_q    <= 1'b0;
            wr_req_q <= 1'b0;
            rd_req_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            err_q    <= 1'b0;
`ifdef SDRAM_ARB_TIMEOUT_EN
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            prio_q   <= prio_d;
            gnt_q    <= gnt_d;
            wr_req_q <= wr_req_d;
            rd_req_q <= rd_req_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            done0_q  <= done0_d;
            done1_q  <= done1_d;
            err_q    <= err_d;
`ifdef SDRAM_ARB_TIMEOUT_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

    assign mem.mem_wr_req = wr_req_q;
    assign mem.mem_rd_req = rd_req_q;
    assign mem.mem_addr   = addr_q;
    assign mem.mem_wdata  = wdata_q;
    assign c0_done        = done0_q;
    assign c1_done        = done1_q;
    assign rdata          = rdata_q;
    assign err            = err_q;

endmodule
